display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Sits between two display requesters and the 8-digit seven-segment DisplayInterface. Requester 0 is the CPU bus bridge; requester 1 is the accelerator status path.
- Grants ownership of the display to one requester at a time with round-robin ties.
- The owner writes the value, point, enable and blink-mask registers.
- Drives value/point/enable into DisplayInterface and applies a hardware blink to masked digits.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 2.
- HOLD_MAX, 1024, maximum cycles one requester may keep the grant while the other is requesting; used only when DISPLAY_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 wants the display
- wr0  in  1  requester 0 write strobe
- addr0  in  2  requester 0 register address
- wdata0  in  32  requester 0 write data
- gnt0  out  1  requester 0 owns the display
- req1, wr1, addr1, wdata1, gnt1: as above for requester 1
- value  out  32  to DisplayInterface value
- point  out  8  to DisplayInterface point
- enable  out  8  to DisplayInterface enable, after blink masking
- blink_phase  out  1  current blink phase, 1 = masked digits blanked

Behaviour:
- Reset values (asynchronous):
  - value=0, point=0, enable_reg=8'hFF, blink_mask=0
  - gnt0=gnt1=0, state=IDLE, last_owner=1, so requester 0 wins the first tie
  - blink counter=0, blink_phase=0, hold counter=0
- Register map (low bits of wdata are used):
  - addr 0: value[31:0]
  - addr 1: point = wdata[7:0]
  - addr 2: enable_reg = wdata[7:0]
  - addr 3: blink_mask = wdata[7:0]
- FSM states are IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both registered.
- IDLE transitions:
  - req0 & req1 -> OWN of !last_owner.
  - Only req0 -> OWN0; only req1 -> OWN1; neither -> stay IDLE.
  - The grant is visible the cycle after req is sampled, so request-to-grant latency is 1 cycle.
- OWNx transitions:
  - Stay while reqx=1.
  - reqx=0 -> IDLE next cycle and last_owner<=x.
  - There is always at least one IDLE cycle between owners; no direct OWN0->OWN1.
- Writes:
  - A register updates on the rising edge where gntx=1 && wrx=1; the new value appears on the outputs the following cycle.
  - A write from a non-owner is silently dropped.
  - A write in the same cycle that reqx falls while gntx is still 1 is accepted.
- Registers hold their contents across ownership changes. Only reset clears them.
- Blink:
  - The counter counts 0..BLINK_DIV-1, then wraps to 0 and toggles blink_phase.
  - enable = enable_reg & ~(blink_mask & {8{blink_phase}}).
  - Writing blink_mask does not reset the counter.
- Reset asserted mid-ownership: grant is dropped immediately, all registers return to reset values, and an in-flight write is lost.

Optional Feature:
- Macro: DISPLAY_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to OWNx and increments each OWNx cycle.
  - If hold counter reaches HOLD_MAX-1 while the other req=1, the FSM forces IDLE next cycle and sets last_owner=x.
  - The preempted requester must deassert and re-request; its req staying high does not regain the grant ahead of the waiting requester, because round-robin resolves the tie.
  - No preemption occurs if the other requester is idle.
- Not defined: no hold counter. Ownership lasts until reqx=0, and HOLD_MAX is ignored.

Decomposition:
- Shared package display_pkg holds:
  - register address constants ADDR_VALUE=0, ADDR_POINT=1, ADDR_ENABLE=2, ADDR_BLINK=3
  - FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2)
  - reset constant ENABLE_RST=8'hFF
- One sub-module: blink_timer (parameter BLINK_DIV; ports clock, reset, phase).

Test Plan (BLINK_DIV=4 and HOLD_MAX=8 in the bench):
1. Reset then idle -> gnt0=gnt1=0, value=0, point=0, enable=8'hFF, blink_phase=0.
2. req0=1, then wr0 addr0 wdata 32'h0000ffff on the first gnt0 cycle -> gnt0 rises 1 cycle after req0; value=32'h0000ffff next cycle.
3. Same write from requester 1 while gnt0=1 -> value unchanged.
4. req0 and req1 asserted together from reset -> OWN0 first. Drop req0 -> one IDLE cycle, then gnt1=1.
5. Write blink_mask=8'h0F with enable_reg=8'hFF -> enable alternates 8'hFF / 8'hF0 every 4 cycles.
6. With DISPLAY_TIMEOUT_EN defined, req0 held continuously and req1 raised at grant cycle 2 -> gnt0 drops after 8 owned cycles, IDLE 1 cycle, gnt1=1. Without the macro, gnt0 stays high.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the display arbiter slice.
//   - Register address map for the owner write port.
//   - Arbiter FSM state encoding.
//   - Reset value of the digit enable register.
package display_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_POINT  = 2'd1;
  localparam logic [1:0] ADDR_ENABLE = 2'd2;
  localparam logic [1:0] ADDR_BLINK  = 2'd3;

  localparam logic [7:0] ENABLE_RST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/blink_timer.sv
// blink_timer: free-running blink phase generator.
//   Counts 0..BLINK_DIV-1, wraps to 0 and toggles the phase on the wrap.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-high reset (counter=0, phase=0)
//   phase  out  current blink phase, 1 = masked digits blanked
module blink_timer #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CntW'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: two-requester round-robin owner of the 8-digit display.
//   Requester 0 is the CPU bus bridge, requester 1 the accelerator status path.
//   The current owner writes value/point/enable/blink-mask registers; enable is
//   masked by the hardware blink phase before it leaves the block.
// Optional feature (macro DISPLAY_TIMEOUT_EN): an owner holding the grant for
//   HOLD_MAX cycles while the other requester waits is forced back to IDLE.
// Ports:
//   clock, reset          system clock / asynchronous active-high reset
//   reqN, wrN             requester N request and write strobe
//   addrN, wdataN         requester N register address and write data
//   gntN                  requester N owns the display (registered)
//   value, point, enable  to DisplayInterface (enable after blink masking)
//   blink_phase           current blink phase, 1 = masked digits blanked
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned HOLD_MAX  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        wr0,
  input  logic [1:0]  addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [1:0]  addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic [31:0] value,
  output logic [7:0]  point,
  output logic [7:0]  enable,
  output logic        blink_phase
);

  if (BLINK_DIV < 2 || HOLD_MAX < 2) begin : g_bad_param
    $error("display_arbiter: BLINK_DIV and HOLD_MAX must be at least 2");
  end

  state_e      r_state;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_last_owner;
  logic [31:0] r_value;
  logic [7:0]  r_point;
  logic [7:0]  r_enable;
  logic [7:0]  r_blink_mask;

  logic        w_phase;
  logic        w_wr_en;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;
  logic        w_rel0;
  logic        w_rel1;

  // Owner release conditions: request dropped, or (optionally) hold timeout.
`ifdef DISPLAY_TIMEOUT_EN
  localparam int unsigned HoldW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  logic [HoldW-1:0] r_hold;
  logic             w_hold_max;

  assign w_hold_max = (r_hold == HoldW'(HOLD_MAX - 1));

  // Cleared in IDLE, which always precedes entry to an OWN state; saturates so
  // a preemption fires as soon as the other side starts requesting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_state == IDLE) begin
      r_hold <= '0;
    end else if (!w_hold_max) begin
      r_hold <= r_hold + HoldW'(1);
    end
  end

  assign w_rel0 = !req0 || (w_hold_max && req1);
  assign w_rel1 = !req1 || (w_hold_max && req0);
`else
  assign w_rel0 = !req0;
  assign w_rel1 = !req1;
`endif

  // Arbiter FSM with registered grants; always one IDLE cycle between owners.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0 && (!req1 || r_last_owner)) begin
            r_state <= OWN0;
            r_gnt0  <= 1'b1;
          end else if (req1) begin
            r_state <= OWN1;
            r_gnt1  <= 1'b1;
          end
        end
        OWN0: begin
          if (w_rel0) begin
            r_state      <= IDLE;
            r_gnt0       <= 1'b0;
            r_last_owner <= 1'b0;
          end
        end
        OWN1: begin
          if (w_rel1) begin
            r_state      <= IDLE;
            r_gnt1       <= 1'b0;
            r_last_owner <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  // Only the current owner's write port reaches the register file.
  always_comb begin
    w_wr_en = 1'b0;
    w_addr  = addr0;
    w_wdata = wdata0;
    if (r_gnt0 && wr0) begin
      w_wr_en = 1'b1;
    end else if (r_gnt1 && wr1) begin
      w_wr_en = 1'b1;
      w_addr  = addr1;
      w_wdata = wdata1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value      <= '0;
      r_point      <= '0;
      r_enable     <= ENABLE_RST;
      r_blink_mask <= '0;
    end else if (w_wr_en) begin
      case (w_addr)
        ADDR_VALUE:  r_value      <= w_wdata;
        ADDR_POINT:  r_point      <= w_wdata[7:0];
        ADDR_ENABLE: r_enable     <= w_wdata[7:0];
        ADDR_BLINK:  r_blink_mask <= w_wdata[7:0];
        default:     r_value      <= r_value;
      endcase
    end
  end

  blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink_timer (
    .clock(clock),
    .reset(reset),
    .phase(w_phase)
  );

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign value       = r_value;
  assign point       = r_point;
  assign enable      = r_enable & ~(r_blink_mask & {8{w_phase}});
  assign blink_phase = w_phase;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (BLINK_DIV=4, HOLD_MAX=8).
// Expected post-edge outputs are pushed to a scoreboard queue when inputs are
// driven and popped/compared one cycle later. Define DISPLAY_TIMEOUT_EN for both
// the bench and the RTL to exercise the hold-timeout preemption.
module tb_display_arbiter;

  localparam int unsigned BlinkDiv = 4;
  localparam int unsigned HoldMax  = 8;

  logic        clock;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [1:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, blink_phase;
  logic [31:0] value;
  logic [7:0]  point, enable;

  display_arbiter #(
    .BLINK_DIV(BlinkDiv),
    .HOLD_MAX (HoldMax)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .wr0        (wr0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .gnt0       (gnt0),
    .req1       (req1),
    .wr1        (wr1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt1       (gnt1),
    .value      (value),
    .point      (point),
    .enable     (enable),
    .blink_phase(blink_phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference blink phase: counts 0..BlinkDiv-1, toggles on wrap.
  int   m_cnt = 0;
  logic m_phase;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
    end else if (m_cnt == int'(BlinkDiv) - 1) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct packed {
    logic        req0;
    logic        wr0;
    logic [1:0]  addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        wr1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic        g0;
    logic        g1;
    logic [31:0] value;
    logic [7:0]  point;
    logic [7:0]  en;
  } vec_t;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [31:0] value;
    logic [7:0]  point;
    logic [7:0]  enable;
    logic        phase;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Push the outputs expected after the next rising edge.
  task automatic push(input logic g0, input logic g1, input logic [31:0] v,
                      input logic [7:0] p, input logic [7:0] en_reg, input logic [7:0] mask);
    exp_t e;
    logic np;
    np       = (m_cnt == int'(BlinkDiv) - 1) ? ~m_phase : m_phase;
    e.g0     = g0;
    e.g1     = g1;
    e.value  = v;
    e.point  = p;
    e.enable = en_reg & ~(mask & {8{np}});
    e.phase  = np;
    sb_q.push_back(e);
  endtask

  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got=none expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " gnt0"}, 32'(gnt0), 32'(e.g0));
      chk({tag, " gnt1"}, 32'(gnt1), 32'(e.g1));
      chk({tag, " value"}, value, e.value);
      chk({tag, " point"}, 32'(point), 32'(e.point));
      chk({tag, " enable"}, 32'(enable), 32'(e.enable));
      chk({tag, " phase"}, 32'(blink_phase), 32'(e.phase));
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [1:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [1:0] a1, input logic [31:0] d1);
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         r0 w0 a0 wdata0        r1 w1 a1 wdata1        g0 g1 value         pt     en
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,
                 1'b1, 1'b0, 32'h0,        8'h00, 8'hFF};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 32'h0000ffff, 1'b0, 1'b0, 2'd0, 32'h0,
                 1'b1, 1'b0, 32'h0000ffff, 8'h00, 8'hFF};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 2'd0, 32'hdeadbeef,
                 1'b1, 1'b0, 32'h0000ffff, 8'h00, 8'hFF};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 32'h000000A5, 1'b1, 1'b0, 2'd0, 32'h0,
                 1'b1, 1'b0, 32'h0000ffff, 8'hA5, 8'hFF};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'h0000003C, 1'b1, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h0000ffff, 8'hA5, 8'h3C};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b1, 32'h0000ffff, 8'hA5, 8'h3C};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 2'd0, 32'h12345678,
                 1'b0, 1'b1, 32'h12345678, 8'hA5, 8'h3C};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h000000FF, 1'b1, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b1, 32'h12345678, 8'hA5, 8'h3C};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 2'd2, 32'hFFFFFF81,
                 1'b0, 1'b1, 32'h12345678, 8'hA5, 8'h81};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0,
                 1'b1, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b1, 32'h12345678, 8'hA5, 8'h81};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,
                 1'b1, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h12345678, 8'hA5, 8'h81};
    vecs[16] = '{1'b0, 1'b1, 2'd0, 32'h00000BAD, 1'b0, 1'b1, 2'd1, 32'h0,
                 1'b0, 1'b0, 32'h12345678, 8'hA5, 8'h81};

    // Reset then idle.
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset gnt0", 32'(gnt0), 32'd0);
    chk("reset gnt1", 32'(gnt1), 32'd0);
    chk("reset value", value, 32'h0);
    chk("reset point", 32'(point), 32'h0);
    chk("reset enable", 32'(enable), 32'hFF);
    chk("reset phase", 32'(blink_phase), 32'd0);
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("idle");

    // Table: grants, owner writes, dropped non-owner writes, round robin.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].req0, vecs[i].wr0, vecs[i].addr0, vecs[i].wdata0,
            vecs[i].req1, vecs[i].wr1, vecs[i].addr1, vecs[i].wdata1);
      push(vecs[i].g0, vecs[i].g1, vecs[i].value, vecs[i].point, vecs[i].en, 8'h00);
      step_check($sformatf("vec%0d", i));
    end

    // Reset while owning with a write in flight: grant drops at once, write lost.
    drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    push(1'b1, 1'b0, 32'h12345678, 8'hA5, 8'h81, 8'h00);
    step_check("own_before_rst");
    drive(1'b1, 1'b1, 2'd0, 32'hCAFEF00D, 1'b0, 1'b0, 2'd0, 32'h0);
    reset = 1'b1;
    #1;
    chk("midrst gnt0", 32'(gnt0), 32'd0);
    chk("midrst value", value, 32'h0);
    chk("midrst point", 32'(point), 32'h0);
    chk("midrst enable", 32'(enable), 32'hFF);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("after_rst");

    // Simultaneous requests from reset: OWN0 first, one IDLE cycle, then OWN1.
    drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
    push(1'b1, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("tie_own0");
    req0 = 1'b0;
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("tie_idle");
    push(1'b0, 1'b1, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("tie_own1");
    req1 = 1'b0;
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("tie_release");

    // Blink: mask low nibble; counter must keep running across the mask write.
    req0 = 1'b1;
    push(1'b1, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h00);
    step_check("blink_grant");
    drive(1'b1, 1'b1, 2'd3, 32'h0000000F, 1'b0, 1'b0, 2'd0, 32'h0);
    push(1'b1, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h0F);
    step_check("blink_wr");
    wr0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      push(1'b1, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h0F);
      step_check($sformatf("blink%0d", k));
    end
    req0 = 1'b0;
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h0F);
    step_check("blink_release");

    // Hold timeout: req0 held, req1 raised on grant cycle 2.
    for (int k = 1; k <= 12; k++) begin
      logic eg0, eg1;
      req0 = 1'b1;
      req1 = (k >= 2);
`ifdef DISPLAY_TIMEOUT_EN
      eg0 = (k <= int'(HoldMax));
      eg1 = (k >= int'(HoldMax) + 2);
`else
      eg0 = 1'b1;
      eg1 = 1'b0;
`endif
      push(eg0, eg1, 32'h0, 8'h00, 8'hFF, 8'h0F);
      step_check($sformatf("hold%0d", k));
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
    push(1'b0, 1'b0, 32'h0, 8'h00, 8'hFF, 8'h0F);
    step_check("hold_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
